// File: rtl/ysyx_24070016_fetch_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_24070016_fetch_seq_pkg
// Purpose : Shared constants for the instruction-fetch sequencer: default
//           datapath width, default reset PC and the 2-bit FSM encodings.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package ysyx_24070016_fetch_seq_pkg;

  localparam int unsigned c_XLEN_DEF     = 32;
  localparam logic [31:0] c_RESET_PC_DEF = 32'h8000_0000;

  // Sequencer states
  localparam logic [1:0] c_ST_REQ  = 2'd0;  // request presented to memory
  localparam logic [1:0] c_ST_WAIT = 2'd1;  // request accepted, awaiting response
  localparam logic [1:0] c_ST_HOLD = 2'd2;  // instruction buffered for the IDU
  localparam logic [1:0] c_ST_HALT = 2'd3;  // stopped after EBREAK, until reset

endpackage
`default_nettype wire

// File: rtl/ysyx_24070016_fetch_seq_RegAr.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_24070016_RegAr
// Purpose : Register with asynchronous active-high reset and load enable.
// Ports   : clk  - clock
//           rst  - asynchronous reset, active-high (loads RESET_VAL)
//           i_en - load enable
//           i_d  - next value
//           o_q  - registered value
// Rev     : 1.0  initial release
// ============================================================================
module ysyx_24070016_RegAr #(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RESET_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/ysyx_24070016_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_24070016_fetch_seq
// Purpose : Multi-cycle instruction-fetch sequencer. Owns the PC, issues one
//           fetch at a time (valid/ready request, single-cycle valid
//           response) and holds the fetched word in a 1-entry buffer for the
//           IDU. Handles redirects, EBREAK halt and fetch-fault tagging.
// Ports   : clk, rst                  - clock, async active-high reset
//           req_valid/ready/addr      - fetch request channel
//           rsp_valid/data/err        - fetch response channel
//           inst_valid/ready          - buffer-to-IDU handshake
//           inst, inst_pc, inst_fault - buffered instruction, its PC, fault tag
//           redirect_valid/pc         - branch/jump target (word aligned here)
//           halt_req, halted          - EBREAK stop request / halted status
// Rev     : 1.0  initial release
// ============================================================================
module ysyx_24070016_fetch_seq
  import ysyx_24070016_fetch_seq_pkg::*;
#(
  parameter int unsigned      XLEN     = c_XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_PC = c_RESET_PC_DEF,
  parameter int unsigned      PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_data,
  input  logic            rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  output logic            halted
);

  localparam logic [XLEN-1:0] c_pc_step    = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] c_align_mask = ~(XLEN'(3));

  // FSM and control flags
  logic [1:0] r_state;
  logic       r_stale;    // in-flight request belongs to a superseded path
  logic       r_hpend;    // halt seen while a response is still owed
  logic       r_started;  // keeps req_valid low in the first cycle out of reset

  logic [1:0] w_state_nx;
  logic       w_stale_nx;
  logic       w_hpend_nx;

  // Datapath register controls
  logic            w_pc_en;
  logic [XLEN-1:0] w_pc_d;
  logic [XLEN-1:0] r_pc;
  logic            w_addr_en;
  logic [XLEN-1:0] w_addr_d;
  logic [XLEN-1:0] r_addr;
  logic            w_buf_en;

  logic            w_accept;
  logic [XLEN-1:0] w_redir_pc;
  logic [XLEN-1:0] w_pc_inc;

  assign req_valid  = (r_state == c_ST_REQ) && r_started;
  assign w_accept   = req_valid && req_ready;
  assign w_redir_pc = redirect_pc & c_align_mask;
  assign w_pc_inc   = r_pc + c_pc_step;

  // The issued address lives in its own register so that a redirect while a
  // request is still unaccepted does not move req_addr under the memory; that
  // old request completes and its response is discarded via r_stale.
  always_comb begin
    w_state_nx = r_state;
    w_stale_nx = r_stale;
    w_hpend_nx = r_hpend;
    w_pc_en    = 1'b0;
    w_pc_d     = r_pc;
    w_addr_en  = 1'b0;
    w_addr_d   = r_pc;
    w_buf_en   = 1'b0;
    case (r_state)
      c_ST_REQ: begin
        if (halt_req) begin
          if (w_accept) begin
            // Request already gone: drain its response before halting.
            w_state_nx = c_ST_WAIT;
            w_hpend_nx = 1'b1;
          end else begin
            w_state_nx = c_ST_HALT;
          end
        end else begin
          if (redirect_valid) begin
            w_pc_en    = 1'b1;
            w_pc_d     = w_redir_pc;
            w_stale_nx = 1'b1;
          end
          if (w_accept) begin
            w_state_nx = c_ST_WAIT;
          end
        end
      end
      c_ST_WAIT: begin
        if (r_hpend || halt_req) begin
          if (rsp_valid) begin
            w_state_nx = c_ST_HALT;
          end else begin
            w_hpend_nx = 1'b1;
          end
        end else if (redirect_valid) begin
          w_pc_en = 1'b1;
          w_pc_d  = w_redir_pc;
          if (rsp_valid) begin
            // The arriving response is for the old path: drop it now.
            w_stale_nx = 1'b0;
            w_addr_en  = 1'b1;
            w_addr_d   = w_redir_pc;
            w_state_nx = c_ST_REQ;
          end else begin
            w_stale_nx = 1'b1;
          end
        end else if (rsp_valid) begin
          if (r_stale) begin
            w_stale_nx = 1'b0;
            w_addr_en  = 1'b1;
            w_addr_d   = r_pc;
            w_state_nx = c_ST_REQ;
          end else begin
            w_buf_en   = 1'b1;
            w_state_nx = c_ST_HOLD;
          end
        end
      end
      c_ST_HOLD: begin
        if (halt_req) begin
          w_state_nx = c_ST_HALT;
        end else if (redirect_valid) begin
          w_pc_en    = 1'b1;
          w_pc_d     = w_redir_pc;
          w_addr_en  = 1'b1;
          w_addr_d   = w_redir_pc;
          w_state_nx = c_ST_REQ;
        end else if (inst_ready) begin
          w_pc_en    = 1'b1;
          w_pc_d     = w_pc_inc;
          w_addr_en  = 1'b1;
          w_addr_d   = w_pc_inc;
          w_state_nx = c_ST_REQ;
        end
      end
      default: begin
        w_state_nx = c_ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_ST_REQ;
      r_stale   <= 1'b0;
      r_hpend   <= 1'b0;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_stale   <= w_stale_nx;
      r_hpend   <= w_hpend_nx;
      r_started <= 1'b1;
    end
  end

  ysyx_24070016_RegAr #(.WIDTH(XLEN), .RESET_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .i_en(w_pc_en), .i_d(w_pc_d), .o_q(r_pc)
  );

  ysyx_24070016_RegAr #(.WIDTH(XLEN), .RESET_VAL(RESET_PC)) u_addr (
    .clk(clk), .rst(rst), .i_en(w_addr_en), .i_d(w_addr_d), .o_q(r_addr)
  );

  ysyx_24070016_RegAr #(.WIDTH(XLEN), .RESET_VAL('0)) u_inst (
    .clk(clk), .rst(rst), .i_en(w_buf_en), .i_d(rsp_data), .o_q(inst)
  );

  ysyx_24070016_RegAr #(.WIDTH(XLEN), .RESET_VAL('0)) u_inst_pc (
    .clk(clk), .rst(rst), .i_en(w_buf_en), .i_d(r_pc), .o_q(inst_pc)
  );

  ysyx_24070016_RegAr #(.WIDTH(1), .RESET_VAL(1'b0)) u_inst_fault (
    .clk(clk), .rst(rst), .i_en(w_buf_en), .i_d(rsp_err), .o_q(inst_fault)
  );

  assign req_addr   = r_addr;
  assign inst_valid = (r_state == c_ST_HOLD);
  assign halted     = (r_state == c_ST_HALT);

endmodule
`default_nettype wire
